// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32 immediate generator (I/S/B/U/J) with a
// 2-entry skid buffer on a valid/ready handshake.
// Optional feature macro: IMM_ILLEGAL_TRAP_EN (flags ImmSrc codes 5..7).
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [2:0]            in_imm_src,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    buf_state_t state, next_state;

    logic                  push, pop;
    logic                  load_head, head_from_skid, load_skid;
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [DATA_WIDTH-1:0] head_imm, skid_imm;
    logic [TAG_W-1:0]      head_tag, skid_tag;
    logic                  unused_opcode;

    // The opcode field never contributes to any immediate format.
    assign unused_opcode = ^in_instr[6:0];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

`ifdef IMM_ILLEGAL_TRAP_EN
    logic dec_ill, head_ill, skid_ill;
`endif

    // Decode the selected format into a 32-bit value whose sign lives in bit 31.
    always_comb begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`ifdef IMM_ILLEGAL_TRAP_EN
        dec_ill = 1'b0;
`endif
        case (in_imm_src)
            3'd0: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'd1: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'd2: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            3'd3: imm32 = {in_instr[31:12], 12'b0};
            3'd4: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            default: begin
`ifdef IMM_ILLEGAL_TRAP_EN
                imm32   = 32'b0;
                dec_ill = 1'b1;
`else
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
            end
        endcase
    end

    // Sign-extend the decoded value to the output width.
    assign dec_imm = DATA_WIDTH'($signed(imm32));

    // Buffer state register; flush empties the buffer regardless of handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= next_state;
    end

    // Next-state logic for the skid buffer occupancy.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (push) next_state = ONE;
            ONE: begin
                if (push && !pop)      next_state = TWO;
                else if (pop && !push) next_state = EMPTY;
            end
            TWO:     if (pop) next_state = ONE;
            default: next_state = EMPTY;
        endcase
    end

    // Handshake outputs and data-register load strobes derived from state only.
    always_comb begin
        in_ready       = (state != TWO);
        out_valid      = (state != EMPTY);
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: load_head = push;
            ONE: begin
                load_head = push & pop;
                load_skid = push & ~pop;
            end
            TWO: begin
                load_head      = pop;
                head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    // Head and skid data registers; they change only on a push or a skid move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_imm <= '0;
            head_tag <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else if (!flush) begin
            if (load_head) begin
                head_imm <= head_from_skid ? skid_imm : dec_imm;
                head_tag <= head_from_skid ? skid_tag : in_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= in_tag;
            end
        end
    end

`ifdef IMM_ILLEGAL_TRAP_EN
    // Illegal flag travels alongside its entry through head and skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ill <= 1'b0;
            skid_ill <= 1'b0;
        end else if (!flush) begin
            if (load_head) head_ill <= head_from_skid ? skid_ill : dec_ill;
            if (load_skid) skid_ill <= dec_ill;
        end
    end
    assign out_illegal = head_ill;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_imm = head_imm;
    assign out_tag = head_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: table of decode vectors, scoreboard of
// expected entries, hand-written stall/flush/reset sequences. Runs a 32-bit and
// a 64-bit instance side by side on identical stimulus.
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, out_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;

    logic             in_ready, out_valid, out_illegal;
    logic [31:0]      out_imm;
    logic [TAG_W-1:0] out_tag;

    logic             in_ready64, out_valid64, out_illegal64;
    logic [63:0]      out_imm64;
    logic [TAG_W-1:0] out_tag64;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[10];

    imm_gen_pipe #(.DATA_WIDTH(32), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.DATA_WIDTH(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, score handshakes, advance.
    task automatic applyStimulus(input logic v, input vec_t x, input logic [TAG_W-1:0] t,
                                 input logic rdy, input logic fl);
        exp_t e;
        in_valid   = v;
        in_instr   = x.instr;
        in_imm_src = x.src;
        in_tag     = t;
        out_ready  = rdy;
        flush      = fl;
        #1;
        checkOutput("handshake_match", {62'b0, in_ready64, out_valid64}, {62'b0, in_ready, out_valid});
        if (fl) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop: got tag %0d expected no entry", out_tag);
                end else begin
                    e = sb.pop_front();
                    checkOutput("imm32", {32'b0, out_imm}, {32'b0, e.imm[31:0]});
                    checkOutput("imm64", out_imm64, e.imm);
                    checkOutput("tag", {59'b0, out_tag}, {59'b0, e.tag});
                    checkOutput("tag64", {59'b0, out_tag64}, {59'b0, e.tag});
                    checkOutput("illegal", {63'b0, out_illegal}, {63'b0, e.ill});
                    checkOutput("illegal64", {63'b0, out_illegal64}, {63'b0, e.ill});
                end
            end
            if (in_valid && in_ready) begin
                e.imm = x.imm;
                e.tag = t;
                e.ill = x.ill;
                sb.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            applyStimulus(1'b0, tbl[0], '0, 1'b1, 1'b0);
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        checkOutput("drain_out_valid", {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        vec_t idle;
        tbl[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        tbl[1] = '{32'h0020A423, 3'd1, 64'h00000000_00000008, 1'b0};
        tbl[2] = '{32'hFE000EE3, 3'd2, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        tbl[3] = '{32'hFF9FF06F, 3'd4, 64'hFFFFFFFF_FFFFFFF8, 1'b0};
        tbl[4] = '{32'h123450B7, 3'd3, 64'h00000000_12345000, 1'b0};
        tbl[5] = '{32'h800000B7, 3'd3, 64'hFFFFFFFF_80000000, 1'b0};
        tbl[6] = '{32'h7FF00013, 3'd0, 64'h00000000_000007FF, 1'b0};
        tbl[7] = '{32'hFE000FA3, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
`ifdef IMM_ILLEGAL_TRAP_EN
        tbl[8] = '{32'hFFF00093, 3'd7, 64'h0, 1'b1};
        tbl[9] = '{32'h00100013, 3'd5, 64'h0, 1'b1};
`else
        tbl[8] = '{32'hFFF00093, 3'd7, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        tbl[9] = '{32'h00100013, 3'd5, 64'h00000000_00000001, 1'b0};
`endif
        idle = tbl[0];

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_imm_src = '0; in_tag = '0;
        #1;
        checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("reset_out_imm", out_imm64, 64'd0);
        checkOutput("reset_out_tag", {59'b0, out_tag}, 64'd0);
        checkOutput("reset_out_illegal", {63'b0, out_illegal}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);

        // Table vectors streamed back-to-back with the consumer always ready.
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, tbl[i], TAG_W'(i + 3), 1'b1, 1'b0);
        drain();

        // Stall: three back-to-back pushes with the consumer blocked.
        applyStimulus(1'b1, tbl[1], 5'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, tbl[2], 5'd2, 1'b0, 1'b0);
        checkOutput("full_in_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("stall_head_tag", {59'b0, out_tag}, 64'd1);
        applyStimulus(1'b1, tbl[3], 5'd3, 1'b0, 1'b0);
        checkOutput("stall_tag_stable", {59'b0, out_tag}, 64'd1);
        checkOutput("stall_imm_stable", {32'b0, out_imm}, 64'h8);
        checkOutput("still_full", {63'b0, in_ready}, 64'd0);
        applyStimulus(1'b1, tbl[3], 5'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, tbl[3], 5'd3, 1'b1, 1'b0);
        applyStimulus(1'b0, tbl[3], 5'd3, 1'b1, 1'b0);
        drain();

        // Flush while full with a valid input present: everything is dropped.
        applyStimulus(1'b1, tbl[4], 5'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, tbl[5], 5'd5, 1'b0, 1'b0);
        applyStimulus(1'b1, tbl[6], 5'd9, 1'b0, 1'b1);
        checkOutput("flush_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("flush_in_ready", {63'b0, in_ready}, 64'd1);
        applyStimulus(1'b0, idle, 5'd0, 1'b1, 1'b0);
        checkOutput("flush_input_dropped", {63'b0, out_valid}, 64'd0);

        // Asynchronous reset in the middle of a stall.
        applyStimulus(1'b1, tbl[0], 5'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, tbl[3], 5'd8, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("midreset_out_imm", {32'b0, out_imm}, 64'd0);
        checkOutput("midreset_out_imm64", out_imm64, 64'd0);
        checkOutput("midreset_out_tag", {59'b0, out_tag}, 64'd0);
        checkOutput("midreset_out_illegal", {63'b0, out_illegal}, 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postreset_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        applyStimulus(1'b1, tbl[4], 5'd11, 1'b1, 1'b0);
        drain();

        // Random valid/ready traffic across all table vectors.
        for (int i = 0; i < 80; i++) begin
            int k;
            k = $urandom_range(0, 9);
            applyStimulus(1'($urandom_range(0, 1)), tbl[k], TAG_W'($urandom),
                          1'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
